// File: rtl/pc_stack_unit_if.sv
// Control-unit side bundle for the program-counter/return-stack unit.
// The master drives the mode strobes and targets; the slave returns the PC and stack status.
interface pc_stack_unit_if #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 8
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic              EN;
  logic              LOAD;
  logic              BRANCH;
  logic              CALL;
  logic              RET;
  logic              CLR_ERR;
  logic [ADDR_W-1:0] DATA_IN;
  logic [ADDR_W-1:0] OFFSET;
  logic [ADDR_W-1:0] DATA_OUT;
  logic [LVL_W-1:0]  STACK_LEVEL;
  logic              STK_EMPTY;
  logic              STK_FULL;
  logic              STK_OVF;
  logic              STK_UNF;

  modport master (
    output EN, LOAD, BRANCH, CALL, RET, CLR_ERR, DATA_IN, OFFSET,
    input  DATA_OUT, STACK_LEVEL, STK_EMPTY, STK_FULL, STK_OVF, STK_UNF
  );

  modport slave (
    input  EN, LOAD, BRANCH, CALL, RET, CLR_ERR, DATA_IN, OFFSET,
    output DATA_OUT, STACK_LEVEL, STK_EMPTY, STK_FULL, STK_OVF, STK_UNF
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with increment, absolute/relative jumps and a LIFO return-address stack.
// Every output comes from registered state; strobes act on the next rising edge.
module pc_stack_unit #(
  parameter int                ADDR_W      = 12,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic            clk,
  input  logic            REST,
  pc_stack_unit_if.slave  bus
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BRANCH,
    OP_RET,
    OP_CALL,
    OP_LOAD
  } op_e;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0]        a,
                                                 input logic signed [ADDR_W-1:0] d);
    return a + $unsigned(d);
  endfunction

  op_e                      op_p0;
  logic signed [ADDR_W-1:0] offset_p0;
  logic [ADDR_W-1:0]        pc_inc_p0;
  logic [ADDR_W-1:0]        pc_p0;
  logic [LVL_W-1:0]         level_p0;
  logic                     ovf_p0;
  logic                     unf_p0;
  logic                     push_p0;
  logic [PTR_W-1:0]         wr_ptr_p0;
  logic [PTR_W-1:0]         top_ptr_p0;
  logic [ADDR_W-1:0]        top_p0;

  logic [ADDR_W-1:0]        pc_p1;
  logic [LVL_W-1:0]         level_p1;
  logic                     ovf_p1;
  logic                     unf_p1;
  logic                     full_p1;
  logic                     empty_p1;

  logic [ADDR_W-1:0]        stack_mem [STACK_DEPTH];

  assign full_p1    = (level_p1 == LVL_W'(STACK_DEPTH));
  assign empty_p1   = (level_p1 == '0);
  assign offset_p0  = bus.OFFSET;
  assign pc_inc_p0  = wrap_inc(pc_p1);
  // Pointer arithmetic wraps mod 2^PTR_W, so a full stack still yields the correct top slot.
  assign wr_ptr_p0  = level_p1[PTR_W-1:0];
  assign top_ptr_p0 = wr_ptr_p0 - PTR_W'(1);
  assign top_p0     = stack_mem[top_ptr_p0];

  always_comb begin
    op_p0 = OP_HOLD;
    if      (bus.LOAD)   op_p0 = OP_LOAD;
    else if (bus.CALL)   op_p0 = OP_CALL;
    else if (bus.RET)    op_p0 = OP_RET;
    else if (bus.BRANCH) op_p0 = OP_BRANCH;
    else if (bus.EN)     op_p0 = OP_INC;
  end

  always_comb begin
    pc_p0    = pc_p1;
    level_p0 = level_p1;
    push_p0  = 1'b0;
    ovf_p0   = ovf_p1 & ~bus.CLR_ERR;
    unf_p0   = unf_p1 & ~bus.CLR_ERR;
    unique case (op_p0)
      OP_LOAD:   pc_p0 = bus.DATA_IN;
      OP_CALL: begin
        if (full_p1) begin
          ovf_p0 = 1'b1;
        end else begin
          push_p0  = 1'b1;
          level_p0 = level_p1 + LVL_W'(1);
          pc_p0    = bus.DATA_IN;
        end
      end
      OP_RET: begin
        if (empty_p1) begin
          unf_p0 = 1'b1;
        end else begin
          level_p0 = level_p1 - LVL_W'(1);
          pc_p0    = top_p0;
        end
      end
      OP_BRANCH: pc_p0 = wrap_add(pc_p1, offset_p0);
      OP_INC:    pc_p0 = pc_inc_p0;
      default:   pc_p0 = pc_p1;
    endcase
  end

  // ---- stage p0 -> p1: control and PC registers ----
  always_ff @(posedge clk or negedge REST) begin
    if (!REST) begin
      pc_p1    <= RESET_VEC;
      level_p1 <= '0;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
    end else begin
      pc_p1    <= pc_p0;
      level_p1 <= level_p0;
      ovf_p1   <= ovf_p0;
      unf_p1   <= unf_p0;
    end
  end

  // Return-address storage carries no reset; a push coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (push_p0 && REST) stack_mem[wr_ptr_p0] <= pc_inc_p0;
  end

  assign bus.DATA_OUT    = pc_p1;
  assign bus.STACK_LEVEL = level_p1;
  assign bus.STK_EMPTY   = empty_p1;
  assign bus.STK_FULL    = full_p1;
  assign bus.STK_OVF     = ovf_p1;
  assign bus.STK_UNF     = unf_p1;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: hand-computed PC, stack level and flag values.
module tb_pc_stack_unit;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LD   = 6'b100000;
  localparam logic [5:0] S_CL   = 6'b010000;
  localparam logic [5:0] S_RT   = 6'b001000;
  localparam logic [5:0] S_BR   = 6'b000100;
  localparam logic [5:0] S_EN   = 6'b000010;
  localparam logic [5:0] S_CE   = 6'b000001;

  logic clk;
  logic REST;
  int   n_chk;
  int   n_pass;

  pc_stack_unit_if #(.ADDR_W(12), .STACK_DEPTH(8)) bus ();

  pc_stack_unit #(.ADDR_W(12), .STACK_DEPTH(8), .RESET_VEC(12'h000)) dut (
    .clk  (clk),
    .REST (REST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic [5:0] s, input logic [11:0] din, input logic [11:0] off);
    {bus.LOAD, bus.CALL, bus.RET, bus.BRANCH, bus.EN, bus.CLR_ERR} = s;
    bus.DATA_IN = din;
    bus.OFFSET  = off;
  endtask

  task automatic cyc(input logic [5:0] s, input logic [11:0] din, input logic [11:0] off);
    drive(s, din, off);
    @(posedge clk);
    #1;
    drive(S_NONE, 12'h000, 12'h000);
  endtask

  logic [11:0] drain_exp [6];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    drive(S_NONE, 12'h000, 12'h000);
    REST = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",    bus.DATA_OUT,    12'h000);
    chk("rst_level", bus.STACK_LEVEL, 0);
    chk("rst_empty", bus.STK_EMPTY,   1);
    chk("rst_full",  bus.STK_FULL,    0);
    chk("rst_ovf",   bus.STK_OVF,     0);
    chk("rst_unf",   bus.STK_UNF,     0);
    REST = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      cyc(S_EN, 12'h000, 12'h000);
      chk("inc", bus.DATA_OUT, i);
    end

    cyc(S_LD, 12'hFFF, 12'h000);  chk("load_fff", bus.DATA_OUT, 12'hFFF);
    cyc(S_EN, 12'h000, 12'h000);  chk("inc_wrap", bus.DATA_OUT, 12'h000);
    cyc(S_LD, 12'h010, 12'h000);  chk("load_010", bus.DATA_OUT, 12'h010);
    cyc(S_BR, 12'h000, 12'hFFC);  chk("br_neg",   bus.DATA_OUT, 12'h00C);
    cyc(S_BR, 12'h000, 12'h005);  chk("br_pos",   bus.DATA_OUT, 12'h011);
    cyc(S_NONE, 12'h3C3, 12'h111); chk("hold",    bus.DATA_OUT, 12'h011);
    cyc(S_LD, 12'h002, 12'h000);
    cyc(S_BR, 12'h000, 12'hFFC);  chk("br_wrap0", bus.DATA_OUT, 12'hFFE);

    cyc(S_LD, 12'h020, 12'h000);
    cyc(S_CL, 12'h100, 12'h000);  chk("call1_pc", bus.DATA_OUT, 12'h100);
    chk("call1_lvl", bus.STACK_LEVEL, 1);
    cyc(S_CL, 12'h200, 12'h000);  chk("call2_pc", bus.DATA_OUT, 12'h200);
    chk("call2_lvl", bus.STACK_LEVEL, 2);
    cyc(S_RT, 12'h000, 12'h000);  chk("ret1_pc",  bus.DATA_OUT, 12'h101);
    cyc(S_RT, 12'h000, 12'h000);  chk("ret2_pc",  bus.DATA_OUT, 12'h021);
    chk("ret2_empty", bus.STK_EMPTY, 1);

    // Stack holds 022, 301..307 after eight calls to 300..307 from PC 021.
    for (int i = 0; i < 8; i++) cyc(S_CL, 12'h300 + 12'(i), 12'h000);
    chk("fill_pc",   bus.DATA_OUT,    12'h307);
    chk("fill_full", bus.STK_FULL,    1);
    chk("fill_lvl",  bus.STACK_LEVEL, 8);
    chk("fill_ovf",  bus.STK_OVF,     0);
    cyc(S_CL, 12'h3AA, 12'h000);
    chk("ovf_pc",   bus.DATA_OUT,    12'h307);
    chk("ovf_flag", bus.STK_OVF,     1);
    chk("ovf_lvl",  bus.STACK_LEVEL, 8);
    cyc(S_CL | S_CE, 12'h3AB, 12'h000);
    chk("ovf_err_wins", bus.STK_OVF, 1);
    cyc(S_CE, 12'h000, 12'h000);
    chk("ovf_clr", bus.STK_OVF, 0);
    chk("ovf_clr_pc", bus.DATA_OUT, 12'h307);

    cyc(S_RT, 12'h000, 12'h000);  chk("pop8", bus.DATA_OUT, 12'h307);
    cyc(S_RT, 12'h000, 12'h000);  chk("pop7", bus.DATA_OUT, 12'h306);
    chk("pop7_lvl", bus.STACK_LEVEL, 6);
    drain_exp = '{12'h305, 12'h304, 12'h303, 12'h302, 12'h301, 12'h022};
    for (int i = 0; i < 6; i++) begin
      cyc(S_RT, 12'h000, 12'h000);
      chk("drain", bus.DATA_OUT, drain_exp[i]);
    end
    chk("drain_empty", bus.STK_EMPTY, 1);

    cyc(S_RT, 12'h000, 12'h000);
    chk("unf_flag", bus.STK_UNF,  1);
    chk("unf_pc",   bus.DATA_OUT, 12'h022);
    cyc(S_RT | S_CE, 12'h000, 12'h000);
    chk("unf_err_wins", bus.STK_UNF, 1);
    cyc(S_CE, 12'h000, 12'h000);
    chk("unf_clr", bus.STK_UNF, 0);

    cyc(S_LD | S_CL | S_EN, 12'h055, 12'h000);
    chk("pri_ld_pc",  bus.DATA_OUT,    12'h055);
    chk("pri_ld_lvl", bus.STACK_LEVEL, 0);
    cyc(S_CL | S_RT | S_BR | S_EN, 12'h0A0, 12'h007);
    chk("pri_cl_pc",  bus.DATA_OUT,    12'h0A0);
    chk("pri_cl_lvl", bus.STACK_LEVEL, 1);
    cyc(S_RT | S_BR | S_EN, 12'h000, 12'h007);
    chk("pri_rt_pc",  bus.DATA_OUT,    12'h056);
    cyc(S_BR | S_EN, 12'h000, 12'h010);
    chk("pri_br_pc",  bus.DATA_OUT,    12'h066);

    cyc(S_CL, 12'h111, 12'h000);
    cyc(S_CL, 12'h222, 12'h000);
    cyc(S_CL, 12'h333, 12'h000);
    chk("pre_rst_lvl", bus.STACK_LEVEL, 3);
    drive(S_CL, 12'h444, 12'h000);
    #2;
    REST = 1'b0;
    #1;
    chk("arst_pc",    bus.DATA_OUT,    12'h000);
    chk("arst_lvl",   bus.STACK_LEVEL, 0);
    chk("arst_empty", bus.STK_EMPTY,   1);
    @(posedge clk);
    #1;
    chk("arst_hold_pc", bus.DATA_OUT, 12'h000);
    drive(S_NONE, 12'h000, 12'h000);
    REST = 1'b1;
    cyc(S_EN, 12'h000, 12'h000);
    chk("post_rst_inc", bus.DATA_OUT, 12'h001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
